// File: rtl/crc_pkg.sv
// Shared constants and FSM encoding for the CRC-16 checker and generator.
package crc_pkg;

    localparam logic [15:0] IBM_POLY  = 16'h8005;
    localparam logic [15:0] PROF_POLY = 16'h1DCF;
    localparam logic [15:0] CRC_INIT  = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_SHIFT,
        ST_CHECK,
        ST_DONE
    } crc_state_e;

endpackage

// File: rtl/crc16_byte.sv
// One-byte CRC-16 update, MSB-first, non-reflected; purely combinational.
module crc16_byte (
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    input  logic [15:0] poly,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {byte_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ poly) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_chk.sv
// Frame CRC checker: header (SOF, LEN) -> payload words -> CRC word -> DONE/STAT.
module crc_chk
    import crc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  DIN_VALID,
    input  logic                  SOF,
    input  logic                  POLY_SEL,
    output logic                  DIN_READY,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  STAT,
    output logic [15:0]           CRC_OUT,
    output logic                  ABORT
);

    crc_state_e            state_q, state_d;
    logic [15:0]           rem_q, rem_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [15:0]           crc_q, crc_d;
    logic                  poly_sel_q, poly_sel_d;
    logic                  stat_q, stat_d;
    logic [15:0]           crc_out_q, crc_out_d;
    logic                  abort_q, abort_d;
    logic                  armed_q, armed_d;

    logic [15:0] poly;
    logic [15:0] crc_nxt;
    logic        accept;
    logic        hdr;

    assign poly = poly_sel_q ? PROF_POLY : IBM_POLY;

    crc16_byte u_crc16_byte (
        .crc_in  (crc_q),
        .byte_in (sh_q[DATA_WIDTH-1 -: 8]),
        .poly    (poly),
        .crc_out (crc_nxt)
    );

    // armed_q keeps DIN_READY low until the first edge after reset release
    assign DIN_READY = armed_q && (state_q == ST_IDLE || state_q == ST_DATA ||
                                   state_q == ST_CHECK);
    assign BUSY      = (state_q == ST_DATA) || (state_q == ST_SHIFT) ||
                       (state_q == ST_CHECK);
    assign DONE      = (state_q == ST_DONE);
    assign STAT      = stat_q;
    assign CRC_OUT   = crc_out_q;
    assign ABORT     = abort_q;

    assign accept = DIN_VALID && DIN_READY;
    assign hdr    = accept && SOF;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        bidx_d     = bidx_q;
        sh_d       = sh_q;
        crc_d      = crc_q;
        poly_sel_d = poly_sel_q;
        stat_d     = stat_q;
        crc_out_d  = crc_out_q;
        abort_d    = 1'b0;
        armed_d    = 1'b1;

        // A header accepted in DATA or CHECK abandons the frame and restarts.
        if (hdr) begin
            rem_d      = DATA_IN[15:0];
            poly_sel_d = POLY_SEL;
            crc_d      = CRC_INIT;
            state_d    = (DATA_IN[15:0] == 16'd0) ? ST_CHECK : ST_DATA;
            abort_d    = (state_q == ST_DATA) || (state_q == ST_CHECK);
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_DATA: begin
                    if (accept) begin
                        sh_d    = DATA_IN;
                        bidx_d  = 2'd0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    crc_d  = crc_nxt;
                    sh_d   = sh_q << 8;
                    rem_d  = rem_q - 16'd1;
                    bidx_d = bidx_q + 2'd1;
                    if (rem_q == 16'd1) begin
                        state_d = ST_CHECK;
                    end else if (bidx_q == 2'd3) begin
                        state_d = ST_DATA;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        stat_d    = (DATA_IN[15:0] == crc_q);
                        crc_out_d = crc_q;
                        state_d   = ST_DONE;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            bidx_q     <= '0;
            sh_q       <= '0;
            crc_q      <= CRC_INIT;
            poly_sel_q <= 1'b0;
            stat_q     <= 1'b0;
            crc_out_q  <= '0;
            abort_q    <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            bidx_q     <= bidx_d;
            sh_q       <= sh_d;
            crc_q      <= crc_d;
            poly_sel_q <= poly_sel_d;
            stat_q     <= stat_d;
            crc_out_q  <= crc_out_d;
            abort_q    <= abort_d;
            armed_q    <= armed_d;
        end
    end

endmodule

// File: tb/tb_crc_chk.sv
// Self-checking bench for crc_chk: directed frames plus randomized frames against a CRC division model.
module tb_crc_chk;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b1;
    logic [31:0] DATA_IN = '0;
    logic        DIN_VALID = 1'b0;
    logic        SOF = 1'b0;
    logic        POLY_SEL = 1'b0;
    logic        DIN_READY;
    logic        BUSY;
    logic        DONE;
    logic        STAT;
    logic [15:0] CRC_OUT;
    logic        ABORT;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int exp_done = 0;
    logic [7:0] pay[$];

    crc_chk #(.DATA_WIDTH(32)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .DATA_IN   (DATA_IN),
        .DIN_VALID (DIN_VALID),
        .SOF       (SOF),
        .POLY_SEL  (POLY_SEL),
        .DIN_READY (DIN_READY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .STAT      (STAT),
        .CRC_OUT   (CRC_OUT),
        .ABORT     (ABORT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (DONE === 1'b1) done_cnt++;
        if (ABORT === 1'b1) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Message * x^16 mod P over the bit stream, i.e. the textbook augmented division.
    function automatic logic [15:0] model_crc(input logic psel);
        logic [15:0] r;
        logic [15:0] p;
        logic        top;
        r = 16'h0000;
        p = psel ? 16'h1DCF : 16'h8005;
        for (int i = 0; i < pay.size() * 8 + 16; i++) begin
            logic bitv;
            logic [7:0] b;
            if (i < pay.size() * 8) begin
                b = pay[i / 8];
                bitv = b[7 - (i % 8)];
            end else begin
                bitv = 1'b0;
            end
            top = r[15];
            r = {r[14:0], bitv};
            if (top) r = r ^ p;
        end
        return r;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic sof, input logic psel, input int gap);
        logic acc;
        acc = 1'b0;
        DATA_IN = d;
        SOF = sof;
        POLY_SEL = psel;
        for (int t = 0; t < 200 && !acc; t++) begin
            DIN_VALID = ($urandom_range(99) >= gap);
            @(negedge CLK);
            acc = DIN_VALID && DIN_READY;
            tick();
        end
        DIN_VALID = 1'b0;
        SOF = 1'b0;
        DATA_IN = $urandom;
        chk("accept", 32'(acc), 32'd1);
    endtask

    task automatic send_header(input logic [15:0] len, input logic psel, input int gap);
        logic [31:0] r;
        r = $urandom;
        send_word({r[31:16], len}, 1'b1, psel, gap);
        chk("busy_hdr", 32'(BUSY), 32'd1);
    endtask

    // Sends up to maxw payload words from pay; unused tail bytes are random.
    task automatic send_payload(input int gap, input int maxw);
        int n;
        int nw;
        int k;
        logic [31:0] w;
        n = pay.size();
        nw = (n + 3) / 4;
        if (nw > maxw) nw = maxw;
        for (int wi = 0; wi < nw; wi++) begin
            for (int b = 0; b < 4; b++) begin
                w[31 - 8*b -: 8] = (4*wi + b < n) ? pay[4*wi + b] : 8'($urandom_range(255));
            end
            send_word(w, 1'b0, 1'b0, gap);
            k = n - 4*wi;
            if (k > 4) k = 4;
            for (int j = 0; j < k; j++) begin
                DIN_VALID = 1'($urandom_range(1));
                DATA_IN = $urandom;
                @(negedge CLK);
                chk("ready_shift", 32'(DIN_READY), 32'd0);
                tick();
            end
            DIN_VALID = 1'b0;
        end
    endtask

    task automatic send_crc(input logic [31:0] word, input logic [15:0] exp_crc,
                            input logic exp_stat, input int gap);
        send_word(word, 1'b0, 1'b0, gap);
        exp_done++;
        @(negedge CLK);
        chk("done_pulse", 32'(DONE), 32'd1);
        chk("busy_done", 32'(BUSY), 32'd0);
        chk("stat", 32'(STAT), 32'(exp_stat));
        chk("crc_out", 32'(CRC_OUT), 32'(exp_crc));
        tick();
        @(negedge CLK);
        chk("done_low", 32'(DONE), 32'd0);
        chk("stat_hold", 32'(STAT), 32'(exp_stat));
        chk("crc_hold", 32'(CRC_OUT), 32'(exp_crc));
        tick();
    endtask

    task automatic reset_seq();
        DIN_VALID = 1'b0;
        SOF = 1'b0;
        RSTN = 1'b0;
        #1;
        chk("rst_ready", 32'(DIN_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_stat", 32'(STAT), 32'd0);
        chk("rst_abort", 32'(ABORT), 32'd0);
        chk("rst_crc", 32'(CRC_OUT), 32'd0);
        tick();
        tick();
        RSTN = 1'b1;
        @(negedge CLK);
        chk("ready_pre_edge", 32'(DIN_READY), 32'd0);
        tick();
        chk("ready_post_edge", 32'(DIN_READY), 32'd1);
    endtask

    task automatic load_123456789();
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] e;
        logic [15:0] len;
        logic        psel;
        logic        good;
        int          dc;

        reset_seq();

        // Reference "123456789" frame, good and bad CRC
        load_123456789();
        send_header(16'd9, 1'b0, 0);
        send_payload(0, 99);
        send_crc(32'h0000FEE8, 16'hFEE8, 1'b1, 0);

        send_header(16'd9, 1'b0, 0);
        send_payload(0, 99);
        r = $urandom;
        send_crc({r[31:16], 16'hFEE9}, 16'hFEE8, 1'b0, 0);

        // Single byte 0x01, both polynomials
        pay.delete();
        pay.push_back(8'h01);
        send_header(16'd1, 1'b1, 0);
        send_payload(0, 99);
        send_crc(32'h00001DCF, 16'h1DCF, 1'b1, 0);
        send_header(16'd1, 1'b0, 0);
        send_payload(0, 99);
        send_crc(32'h00001DCF, 16'h8005, 1'b0, 0);

        // Empty frame
        send_header(16'd0, 1'b0, 0);
        send_crc(32'h00000000, 16'h0000, 1'b1, 0);

        // Abort in DATA after the first payload word, then the new frame completes
        load_123456789();
        send_header(16'd9, 1'b0, 0);
        send_payload(0, 1);
        dc = done_cnt;
        send_header(16'd9, 1'b0, 0);
        chk("abort_data", 32'(ABORT), 32'd1);
        tick();
        chk("abort_clear", 32'(ABORT), 32'd0);
        chk("no_done_abort", 32'(done_cnt), 32'(dc));
        send_payload(0, 99);
        send_crc(32'h0000FEE8, 16'hFEE8, 1'b1, 0);

        // Abort while waiting for the CRC word
        send_header(16'd0, 1'b0, 0);
        send_header(16'd1, 1'b1, 0);
        chk("abort_check", 32'(ABORT), 32'd1);
        pay.delete();
        pay.push_back(8'h01);
        send_payload(0, 99);
        send_crc(32'h00001DCF, 16'h1DCF, 1'b1, 0);

        // Reset in the middle of SHIFT
        load_123456789();
        send_header(16'd9, 1'b0, 0);
        send_word(32'h31323334, 1'b0, 1'b0, 0);
        dc = done_cnt;
        @(negedge CLK);
        reset_seq();
        chk("rst_no_done", 32'(done_cnt), 32'(dc));
        send_header(16'd9, 1'b0, 0);
        send_payload(0, 99);
        send_crc(32'h0000FEE8, 16'hFEE8, 1'b1, 0);

        // Reference frame under random DIN_VALID
        send_header(16'd9, 1'b0, 40);
        send_payload(40, 99);
        send_crc(32'h0000FEE8, 16'hFEE8, 1'b1, 40);

        // Random frames against the division model
        for (int f = 0; f < 20; f++) begin
            len = (f == 7) ? 16'd300 : 16'($urandom_range(0, 40));
            psel = 1'($urandom_range(1));
            good = 1'($urandom_range(1));
            pay.delete();
            for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom_range(255)));
            e = model_crc(psel);
            r = $urandom;
            send_header(len, psel, 30);
            send_payload(30, 99);
            send_crc({r[31:16], good ? e : (e ^ (16'h0001 << $urandom_range(15)))}, e, good, 30);
        end

        tick();
        chk("done_total", 32'(done_cnt), 32'(exp_done));
        chk("abort_total", 32'(abort_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
